// File: rtl/uart_recv.sv
// uart_recv: UART receiver, LSB first. Default frame is 8N1. Define
// UART_RECV_PARITY_EN to receive 8E1 frames with a parity check.
//
// The serial line is synchronised through two flops, and a third flop
// detects the falling edge of the start bit. The start bit is sampled at
// mid-bit, and then each data, parity and stop bit is sampled one bit
// period later. The receiver returns to IDLE at mid-stop so that
// back-to-back frames with no idle time between them are accepted.
//
// Parameters:
//   CLK_FREQ  clk_i frequency in Hz
//   UART_BPS  baud rate; BPS_CNT = CLK_FREQ/UART_BPS must be in [4, 65535]
//
// Ports:
//   clk_i           system clock
//   rst_n_i         asynchronous reset, active low
//   uart_rxd_i      serial line input, asynchronous to clk_i, idles high
//   uart_dout_o     last good received byte, held until the next good frame
//   uart_done_o     1-cycle pulse; uart_dout_o is valid from this cycle on
//   uart_ferr_o     1-cycle pulse when the stop bit is sampled 0
//   uart_perr_o     1-cycle pulse on a parity error (parity build only, else 0)
//   uart_rx_busy_o  high from start detect until the frame ends
module uart_recv #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned UART_BPS = 9600
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       uart_rxd_i,
    output logic [7:0] uart_dout_o,
    output logic       uart_done_o,
    output logic       uart_ferr_o,
    output logic       uart_perr_o,
    output logic       uart_rx_busy_o
);

    localparam int unsigned BPS_CNT   = CLK_FREQ / UART_BPS;
    localparam int unsigned HALF_CNT  = BPS_CNT / 2;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned BIT_W     = 4;
    localparam logic [CNT_W-1:0] BPS_LAST  = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state;
    logic             rx_d0;
    logic             rx_d1;
    logic             rx_d2;
    logic [CNT_W-1:0] clk_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [7:0]       shift_r;
    logic             fall_edge_c;

    // A start edge is a synchronised 1 followed by a synchronised 0
    assign fall_edge_c = rx_d2 & ~rx_d1;

`ifdef UART_RECV_PARITY_EN
    logic par_r;
    logic par_bad_c;

    // Even parity: the XOR over the data bits and the parity bit must be 0
    assign par_bad_c = ^{shift_r, par_r};
`else
    assign uart_perr_o = 1'b0;
`endif

    // Synchroniser, receive FSM and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_d0          <= 1'b1;
            rx_d1          <= 1'b1;
            rx_d2          <= 1'b1;
            state          <= IDLE;
            clk_cnt        <= '0;
            bit_cnt        <= '0;
            shift_r        <= '0;
            uart_dout_o    <= 8'h00;
            uart_done_o    <= 1'b0;
            uart_ferr_o    <= 1'b0;
            uart_rx_busy_o <= 1'b0;
`ifdef UART_RECV_PARITY_EN
            par_r          <= 1'b0;
            uart_perr_o    <= 1'b0;
`endif
        end else begin
            rx_d0       <= uart_rxd_i;
            rx_d1       <= rx_d0;
            rx_d2       <= rx_d1;
            uart_done_o <= 1'b0;
            uart_ferr_o <= 1'b0;
`ifdef UART_RECV_PARITY_EN
            uart_perr_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fall_edge_c) begin
                        state          <= START;
                        clk_cnt        <= '0;
                        bit_cnt        <= '0;
                        uart_rx_busy_o <= 1'b1;
                    end
                end
                START: begin
                    // Sample the start bit at mid-bit. A high line means it was a glitch.
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        if (!rx_d1) begin
                            state <= DATA;
                        end else begin
                            state          <= IDLE;
                            uart_rx_busy_o <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == BPS_LAST) begin
                        clk_cnt                <= '0;
                        shift_r[bit_cnt[2:0]]  <= rx_d1;
                        if (bit_cnt == BIT_W'(7)) begin
                            bit_cnt <= '0;
`ifdef UART_RECV_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RECV_PARITY_EN
                PARITY: begin
                    if (clk_cnt == BPS_LAST) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        par_r   <= rx_d1;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    // Leave at mid-stop so that a start edge right after it can be caught
                    if (clk_cnt == BPS_LAST) begin
                        clk_cnt        <= '0;
                        bit_cnt        <= '0;
                        state          <= IDLE;
                        uart_rx_busy_o <= 1'b0;
                        if (!rx_d1) begin
                            uart_ferr_o <= 1'b1;
                        end
`ifdef UART_RECV_PARITY_EN
                        if (par_bad_c) begin
                            uart_perr_o <= 1'b1;
                        end
                        if (rx_d1 && !par_bad_c) begin
                            uart_dout_o <= shift_r;
                            uart_done_o <= 1'b1;
                        end
`else
                        if (rx_d1) begin
                            uart_dout_o <= shift_r;
                            uart_done_o <= 1'b1;
                        end
`endif
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state          <= IDLE;
                    clk_cnt        <= '0;
                    bit_cnt        <= '0;
                    uart_rx_busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
